spi_slave_rx_wr_ctrl: RTL and testbench



---
 rtl/spi_slave_rx_wr_ctrl.sv | 148 ++++++++++++++
 tb/tb_spi_slave_rx_wr_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_wr_ctrl.sv
// ----------------------------------------------------------------------------
// spi_slave_rx_wr_ctrl
// Write controller on the AXI side of the SPI slave. Pops 32-bit words from
// the SPI-to-AXI FIFO and issues one single-beat write per word at an
// incrementing word address. It waits for each write response before it
// accepts the next word.
//
// Ports:
//   axi_aclk, axi_aresetn      clock, asynchronous active-low reset
//   cfg_start_i/addr_i/len_i   transfer start pulse, byte start address,
//                              word count (sampled on the start pulse)
//   rx_data_i/valid_i/ready_o  FIFO word stream
//   wr_req_o/addr_o/data_o     write request, held stable until wr_gnt_i
//   wr_gnt_i                   request accepted
//   wr_rsp_valid_i/err_i       write response and its error flag
//   busy_o, done_o, err_o      status: in transfer, end pulse, sticky error
// ----------------------------------------------------------------------------
module spi_slave_rx_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  cfg_start_i,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
    input  logic [LEN_WIDTH-1:0]  cfg_len_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  wr_req_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic                  wr_gnt_i,
    input  logic                  wr_rsp_valid_i,
    input  logic                  wr_rsp_err_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    // Byte step between consecutive 32-bit words
    localparam int unsigned ADDR_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_REQ       = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  done_q,   done_d;
    logic                  err_q,    err_d;

    // State and datapath registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    err_d = 1'b0;
                    if (cfg_len_i == LEN_WIDTH'(0)) begin
                        // Empty transfer: report completion without touching the FIFO
                        done_d = 1'b1;
                    end else begin
                        addr_d   = cfg_addr_i;
                        remain_d = cfg_len_i;
                        state_d  = ST_WAIT_DATA;
                    end
                end
            end

            ST_WAIT_DATA: begin
                if (rx_valid_i) begin
                    data_d  = rx_data_i;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (wr_gnt_i) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (wr_rsp_valid_i) begin
                    // An error is recorded but the transfer keeps draining the
                    // FIFO so the SPI stream stays aligned with the command
                    if (wr_rsp_err_i) begin
                        err_d = 1'b1;
                    end
                    addr_d   = addr_q + ADDR_WIDTH'(ADDR_STEP);
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode straight from the state register
    assign rx_ready_o = (state_q == ST_WAIT_DATA);
    assign wr_req_o   = (state_q == ST_REQ);
    assign busy_o     = (state_q != ST_IDLE);
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_spi_slave_rx_wr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_rx_wr_ctrl
// Self-checking bench: directed vector table, hand-written reset and
// restart sequences, and randomized transfers checked against an
// address/data list computed from the start address and word count.
// ----------------------------------------------------------------------------
module tb_spi_slave_rx_wr_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW-1:0] cfg_addr;
    logic [LW-1:0] cfg_len;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          rsp_valid;
    logic          rsp_err;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_slave_rx_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .axi_aclk       (clk),
        .axi_aresetn    (rst_n),
        .cfg_start_i    (cfg_start),
        .cfg_addr_i     (cfg_addr),
        .cfg_len_i      (cfg_len),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .rx_ready_o     (rx_ready),
        .wr_req_o       (wr_req),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .wr_gnt_i       (wr_gnt),
        .wr_rsp_valid_i (rsp_valid),
        .wr_rsp_err_i   (rsp_err),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_wr_req"},   32'(wr_req),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_wr_addr"},  wr_addr,       32'd0);
        chk({tag, "_wr_data"},  wr_data,       32'd0);
    endtask

    // One complete transfer. The bench acts as FIFO and write slave with the
    // given delays; every cycle is observed on the falling edge, where the
    // inputs for the next rising edge are also chosen.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input int len,
                            input logic [31:0] emask, input int vd, input int gd,
                            input int rd, input logic exp_err, input bit rnd,
                            input bit mid, input int exp_cyc,
                            output logic [31:0] last_wr);
        logic [31:0] words[$];
        logic [31:0] got_addr[$];
        logic [31:0] got_data[$];
        logic [31:0] a;
        logic [31:0] prev_addr, prev_data;
        int   cyc, done_cnt, done_cyc, idx, beat, wc, gc, rc, n;
        bit   pending, prev_req, prev_gnt;
        bit   busy_bad, stable_bad, overlap_bad, len0_bad, err_drop, err_seen;

        for (int i = 0; i < len; i++) words.push_back($urandom);
        cyc = 0; done_cnt = 0; done_cyc = -1; idx = 0; beat = 0;
        wc = 0; gc = 0; rc = 0; pending = 0; prev_req = 0; prev_gnt = 0;
        prev_addr = '0; prev_data = '0;
        busy_bad = 0; stable_bad = 0; overlap_bad = 0; len0_bad = 0;
        err_drop = 0; err_seen = 0;
        last_wr = '0;

        @(negedge clk);
        cfg_start = 1'b1; cfg_addr = addr; cfg_len = LW'(len);
        rx_valid = 1'b0; wr_gnt = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        chk({tag, "_err_cleared"}, 32'(err), 32'd0);

        while (cyc < 400 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
            cfg_start = 1'b0;
            if (mid && cyc == 4) begin
                cfg_start = 1'b1;
                cfg_addr  = addr ^ 32'h00F0_0000;
                cfg_len   = LW'(7);
            end

            // Observe
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (len == 0 && busy) busy_bad = 1;
            if (len != 0 && done_cnt == 0 && !busy) busy_bad = 1;
            if (done_cnt > 0 && busy) busy_bad = 1;
            if (rx_ready && wr_req) overlap_bad = 1;
            if (len == 0 && (rx_ready || wr_req)) len0_bad = 1;
            if (wr_req && prev_req && !prev_gnt &&
                (wr_addr !== prev_addr || wr_data !== prev_data)) stable_bad = 1;
            if (err_seen && !err) err_drop = 1;
            if (err) err_seen = 1;

            // Write response for the outstanding beat
            rsp_valid = 1'b0; rsp_err = 1'b0;
            if (pending) begin
                if (rc >= rd) begin
                    rsp_valid = 1'b1;
                    rsp_err   = emask[beat];
                    beat++;
                    pending = 0;
                    rc = 0;
                end else begin
                    rc++;
                end
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                // Stray error response while nothing is outstanding
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end

            // Grant
            wr_gnt = 1'b0;
            if (wr_req) begin
                if (gc >= gd) begin
                    wr_gnt = 1'b1;
                    got_addr.push_back(wr_addr);
                    got_data.push_back(wr_data);
                    pending = 1;
                    gc = 0;
                end else begin
                    gc++;
                end
            end
            prev_req = wr_req; prev_gnt = wr_gnt;
            prev_addr = wr_addr; prev_data = wr_data;

            // FIFO
            rx_valid = 1'b0;
            if (idx < len) begin
                if (rx_ready) begin
                    if (wc >= vd) begin
                        rx_valid = 1'b1;
                        rx_data  = words[idx];
                        idx++;
                        wc = 0;
                    end else begin
                        wc++;
                    end
                end else if (rnd && $urandom_range(0, 1) == 1) begin
                    // Word already waiting while the controller is not ready
                    rx_valid = 1'b1;
                    rx_data  = words[idx];
                end
            end

            @(negedge clk);
            cyc++;
        end
        cfg_start = 1'b0; rx_valid = 1'b0; wr_gnt = 1'b0;
        rsp_valid = 1'b0; rsp_err = 1'b0;

        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        chk({tag, "_num_writes"}, 32'(got_addr.size()), 32'(len));
        n = (got_addr.size() < len) ? got_addr.size() : len;
        a = addr;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), got_addr[i], a);
            chk($sformatf("%s_data%0d", tag, i), got_data[i], words[i]);
            a = a + 32'd4;
        end
        if (got_addr.size() > 0) last_wr = got_addr[got_addr.size() - 1];
        chk({tag, "_consumed"},    32'(idx),         32'(len));
        chk({tag, "_err"},         32'(err),         32'(exp_err));
        chk({tag, "_busy"},        32'(busy_bad),    32'd0);
        chk({tag, "_req_stable"},  32'(stable_bad),  32'd0);
        chk({tag, "_ready_req"},   32'(overlap_bad), 32'd0);
        chk({tag, "_len0_quiet"},  32'(len0_bad),    32'd0);
        chk({tag, "_err_sticky"},  32'(err_drop),    32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [31:0] emask;
        int          vd;
        int          gd;
        int          rd;
        logic [31:0] exp_last;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [31:0] last;
        logic [31:0] ra, em;
        logic        ee;
        int          rl, k;

        // Directed vectors; done cycle = sum over words of (1+vd)+(1+gd)+(1+rd)
        vecs[0] = '{32'h0000_1000, 3, 32'h0, 0, 1, 0, 32'h0000_1008, 1'b0, 12};
        vecs[1] = '{32'h0000_4000, 4, 32'h2, 0, 0, 0, 32'h0000_400C, 1'b1, 12};
        vecs[2] = '{32'h0000_0000, 0, 32'h0, 0, 0, 0, 32'h0000_0000, 1'b0, 0};
        vecs[3] = '{32'h0000_5000, 2, 32'h0, 0, 5, 0, 32'h0000_5004, 1'b0, 16};
        vecs[4] = '{32'hFFFF_FFFC, 2, 32'h0, 0, 0, 0, 32'h0000_0000, 1'b0, 6};
        vecs[5] = '{32'h0000_0100, 1, 32'h0, 2, 0, 3, 32'h0000_0100, 1'b0, 8};

        rst_n = 1'b0; cfg_start = 1'b0; cfg_addr = '0; cfg_len = '0;
        rx_data = '0; rx_valid = 1'b0; wr_gnt = 1'b0;
        rsp_valid = 1'b0; rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].emask,
                     vecs[i].vd, vecs[i].gd, vecs[i].rd, vecs[i].exp_err, 1'b0, 1'b0,
                     vecs[i].exp_cyc, last);
            if (vecs[i].len != 0) chk($sformatf("vec%0d_last_addr", i), last, vecs[i].exp_last);
        end

        // Restart request mid-transfer must be ignored
        run_xfer("midstart", 32'h0000_7000, 4, 32'h0, 0, 1, 1, 1'b0, 1'b0, 1'b1, 20, last);
        chk("midstart_last_addr", last, 32'h0000_700C);

        // Reset while waiting for the first response of a 3-word transfer
        @(negedge clk);
        cfg_start = 1'b1; cfg_addr = 32'h0000_3000; cfg_len = LW'(3);
        @(negedge clk);
        cfg_start = 1'b0;
        rx_valid = 1'b1; rx_data = 32'h0000_00B0;
        @(negedge clk);
        rx_valid = 1'b0;
        k = 0;
        while (!wr_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_seq_req_seen", 32'(wr_req), 32'd1);
        chk("rst_seq_req_data", wr_data, 32'h0000_00B0);
        wr_gnt = 1'b1;
        @(negedge clk);
        wr_gnt = 1'b0;
        rx_valid = 1'b1; rx_data = 32'h0000_00B1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 32'(rx_ready), 32'd0);
        chk("midrst_busy_after",  32'(busy),     32'd0);
        rx_valid = 1'b0;
        run_xfer("post_rst", 32'h0000_2000, 1, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 3, last);
        chk("post_rst_last_addr", last, 32'h0000_2000);

        // Randomized transfers with random delays, errors and stray inputs
        for (int t = 0; t < 30; t++) begin
            ra = $urandom & 32'hFFFF_FFFC;
            if (t % 5 == 0) ra = 32'hFFFF_FFF0;
            rl = $urandom_range(1, 6);
            em = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h3F) : 32'h0;
            ee = 1'b0;
            for (int i = 0; i < rl; i++) if (em[i]) ee = 1'b1;
            run_xfer($sformatf("rnd%0d", t), ra, rl, em,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     ee, 1'b1, (t % 7 == 3), -1, last);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
